// File: rtl/lc3_wait_mem.sv
// rtl/lc3_wait_mem.sv - dual-channel word memory with per-channel programmable wait states
module lc3_wait_mem #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h3000,
    parameter int                LAT_W      = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instrmem_rd,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              data_req,
    input  logic              Data_rd,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    input  logic [LAT_W-1:0]  lat_instr,
    input  logic [LAT_W-1:0]  lat_data,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [31:0]       instr_cnt,
    output logic [31:0]       data_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t                i_state;
    logic [LAT_W-1:0]      i_cnt;
    logic [DEPTH_LOG2-1:0] i_idx;

    state_t                d_state;
    logic [LAT_W-1:0]      d_cnt;
    logic [DEPTH_LOG2-1:0] d_idx;
    logic                  d_rd;
    logic [DATA_W-1:0]     d_din;

    logic                  i_done;
    logic                  d_done;
    logic [DEPTH_LOG2-1:0] i_ridx;
    logic [DEPTH_LOG2-1:0] d_ridx;
    logic                  d_rsel;
    logic [DATA_W-1:0]     d_wdat;
    logic                  d_we;

    // Addresses outside the window simply wrap onto the array.
    function automatic logic [DEPTH_LOG2-1:0] widx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] d;
        d = a - BASE_ADDR;
        return d[DEPTH_LOG2-1:0];
    endfunction

    // Completion is gated by reset so nothing completes, counts or writes while held.
    assign i_done = reset && ((i_state == S_IDLE && instrmem_rd && lat_instr == '0) ||
                              (i_state == S_WAIT && i_cnt == LAT_W'(1)));
    assign d_done = reset && ((d_state == S_IDLE && data_req && lat_data == '0) ||
                              (d_state == S_WAIT && d_cnt == LAT_W'(1)));

    assign i_ridx = (i_state == S_WAIT) ? i_idx : widx(pc);
    assign d_ridx = (d_state == S_WAIT) ? d_idx : widx(Data_addr);
    assign d_rsel = (d_state == S_WAIT) ? d_rd  : Data_rd;
    assign d_wdat = (d_state == S_WAIT) ? d_din : Data_din;
    assign d_we   = d_done && !d_rsel;

    assign complete_instr = i_done;
    assign complete_data  = d_done;
    assign Instr_dout     = i_done ? mem[i_ridx] : '0;
    assign Data_dout      = (d_done && d_rsel) ? mem[d_ridx] : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            i_state <= S_IDLE;
            i_cnt   <= '0;
            i_idx   <= '0;
        end else begin
            case (i_state)
                S_IDLE: begin
                    if (instrmem_rd && lat_instr != '0) begin
                        i_state <= S_WAIT;
                        i_cnt   <= lat_instr;
                        i_idx   <= widx(pc);
                    end
                end
                S_WAIT: begin
                    i_cnt <= i_cnt - LAT_W'(1);
                    if (i_cnt == LAT_W'(1))
                        i_state <= S_IDLE;
                end
                default: i_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            d_state <= S_IDLE;
            d_cnt   <= '0;
            d_idx   <= '0;
            d_rd    <= 1'b0;
            d_din   <= '0;
        end else begin
            case (d_state)
                S_IDLE: begin
                    if (data_req && lat_data != '0) begin
                        d_state <= S_WAIT;
                        d_cnt   <= lat_data;
                        d_idx   <= widx(Data_addr);
                        d_rd    <= Data_rd;
                        d_din   <= Data_din;
                    end
                end
                S_WAIT: begin
                    d_cnt <= d_cnt - LAT_W'(1);
                    if (d_cnt == LAT_W'(1))
                        d_state <= S_IDLE;
                end
                default: d_state <= S_IDLE;
            endcase
        end
    end

    // Preload is ordered last so it overrides a data write to the same word.
    always_ff @(posedge clock) begin
        if (d_we)
            mem[d_ridx] <= d_wdat;
        if (load_en)
            mem[widx(load_addr)] <= load_data;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            instr_cnt <= '0;
            data_cnt  <= '0;
        end else begin
            if (i_done && instr_cnt != 32'hFFFF_FFFF)
                instr_cnt <= instr_cnt + 32'd1;
            if (d_done && data_cnt != 32'hFFFF_FFFF)
                data_cnt <= data_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_lc3_wait_mem.sv
// tb/tb_lc3_wait_mem.sv - vector table plus completion scoreboard for lc3_wait_mem
module tb_lc3_wait_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic        instrmem_rd;
    logic [15:0] pc;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        data_req;
    logic        Data_rd;
    logic [15:0] Data_addr;
    logic [15:0] Data_din;
    logic [15:0] Data_dout;
    logic        complete_data;
    logic [2:0]  lat_instr;
    logic [2:0]  lat_data;
    logic        load_en;
    logic [15:0] load_addr;
    logic [15:0] load_data;
    logic [31:0] instr_cnt;
    logic [31:0] data_cnt;

    lc3_wait_mem dut (
        .clock(clock), .reset(reset),
        .instrmem_rd(instrmem_rd), .pc(pc), .Instr_dout(Instr_dout), .complete_instr(complete_instr),
        .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
        .Data_dout(Data_dout), .complete_data(complete_data),
        .lat_instr(lat_instr), .lat_data(lat_data),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .instr_cnt(instr_cnt), .data_cnt(data_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] laddr;
        logic [15:0] ldata;
        logic [15:0] raddr;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    vec_t vt [5];
    exp_t iq [$];
    exp_t dq [$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   n_i   = 0;
    int   n_d   = 0;
    int   c0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_i(input logic [15:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        iq.push_back(e);
        n_i++;
    endtask

    task automatic push_d(input logic [15:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        dq.push_back(e);
        n_d++;
    endtask

    // Every completion must match the oldest outstanding expectation in cycle and data.
    always @(negedge clock) begin
        exp_t e;
        if (complete_instr === 1'b1) begin
            if (iq.size() == 0) begin
                total++; bad++;
                $display("FAIL instr_unexpected cyc=%0d actual=1 expected=0", cyc);
            end else begin
                e = iq.pop_front();
                check("instr_cycle", cyc, e.cyc);
                check("instr_data", {16'h0, Instr_dout}, {16'h0, e.data});
            end
        end else begin
            check("instr_idle_zero", {16'h0, Instr_dout}, 32'h0);
        end
        if (complete_data === 1'b1) begin
            if (dq.size() == 0) begin
                total++; bad++;
                $display("FAIL data_unexpected cyc=%0d actual=1 expected=0", cyc);
            end else begin
                e = dq.pop_front();
                check("data_cycle", cyc, e.cyc);
                check("data_data", {16'h0, Data_dout}, {16'h0, e.data});
            end
        end else begin
            check("data_idle_zero", {16'h0, Data_dout}, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{16'h3000, 16'h1234, 16'h3000, 16'h1234};
        vt[1] = '{16'h3001, 16'h00AA, 16'h3401, 16'h00AA};
        vt[2] = '{16'h33FF, 16'h5A5A, 16'h33FF, 16'h5A5A};
        vt[3] = '{16'h2FFF, 16'h0F0F, 16'h33FF, 16'h0F0F};
        vt[4] = '{16'h7000, 16'hC0DE, 16'h3000, 16'hC0DE};

        reset = 1'b0; instrmem_rd = 1'b0; pc = 16'h3000;
        data_req = 1'b0; Data_rd = 1'b1; Data_addr = 16'h3000; Data_din = 16'h0;
        lat_instr = 3'd0; lat_data = 3'd0;
        load_en = 1'b0; load_addr = 16'h0; load_data = 16'h0;

        // Reset: lat-0 requests must not complete; preload still works.
        step();
        instrmem_rd = 1'b1; data_req = 1'b1; Data_rd = 1'b1;
        load_en = 1'b1; load_addr = 16'h3020; load_data = 16'h7777;
        @(negedge clock);
        check("rst_complete_instr", {31'h0, complete_instr}, 32'h0);
        check("rst_complete_data", {31'h0, complete_data}, 32'h0);
        check("rst_instr_cnt", instr_cnt, 32'h0);
        check("rst_data_cnt", data_cnt, 32'h0);
        step();
        load_addr = 16'h3010; load_data = 16'h0001;
        step();
        load_en = 1'b0; instrmem_rd = 1'b0; data_req = 1'b0; reset = 1'b1;
        step();

        // Lat-0 reads on both channels, held two cycles each.
        for (int i = 0; i < 5; i++) begin
            load_en = 1'b1; load_addr = vt[i].laddr; load_data = vt[i].ldata;
            instrmem_rd = 1'b0; data_req = 1'b0;
            step();
            load_en = 1'b0;
            pc = vt[i].raddr; instrmem_rd = 1'b1; lat_instr = 3'd0;
            Data_addr = vt[i].raddr; Data_rd = 1'b1; data_req = 1'b1; lat_data = 3'd0;
            push_i(vt[i].exp, cyc); push_d(vt[i].exp, cyc);
            @(negedge clock);
            check("vec_complete_instr", {31'h0, complete_instr}, 32'h1);
            check("vec_complete_data", {31'h0, complete_data}, 32'h1);
            step();
            push_i(vt[i].exp, cyc); push_d(vt[i].exp, cyc);
            step();
        end
        instrmem_rd = 1'b0; data_req = 1'b0;
        step();

        // lat 3 write, inputs changed while waiting, then lat 0 read-back.
        lat_data = 3'd3; data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3005; Data_din = 16'hBEEF;
        c0 = cyc;
        push_d(16'h0, c0 + 3);
        step();
        data_req = 1'b0; lat_data = 3'd1; Data_addr = 16'h3006; Data_din = 16'h0000;
        step(); step(); step();
        lat_data = 3'd0; data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h3005;
        push_d(16'hBEEF, cyc);
        step();
        data_req = 1'b0;
        step();

        // lat 5 fetch, request dropped and latency/pc changed mid-wait.
        lat_instr = 3'd5; instrmem_rd = 1'b1; pc = 16'h3000;
        c0 = cyc;
        push_i(16'hC0DE, c0 + 5);
        step();
        lat_instr = 3'd1; instrmem_rd = 1'b0; pc = 16'h3001;
        repeat (5) step();

        // Back-to-back lat 2 reads with request held high.
        lat_data = 3'd2; data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h3005;
        c0 = cyc;
        push_d(16'hBEEF, c0 + 2); push_d(16'hBEEF, c0 + 5);
        repeat (6) step();
        data_req = 1'b0;
        step();

        // Reset while a lat 4 write is in flight.
        lat_data = 3'd4; data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3020; Data_din = 16'h1111;
        step();
        data_req = 1'b0;
        step();
        reset = 1'b0; n_i = 0; n_d = 0;
        step();
        reset = 1'b1;
        repeat (5) step();
        @(negedge clock);
        check("inflight_rst_data_cnt", data_cnt, 32'h0);
        check("inflight_rst_instr_cnt", instr_cnt, 32'h0);
        step();
        lat_data = 3'd0; data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h3020;
        push_d(16'h7777, cyc);
        step();
        data_req = 1'b0;

        // Same-cycle lat 0 fetch and write to one word: fetch sees old value.
        lat_instr = 3'd0; instrmem_rd = 1'b1; pc = 16'h3010;
        data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3010; Data_din = 16'h0002;
        push_i(16'h0001, cyc); push_d(16'h0000, cyc);
        step();
        data_req = 1'b0;
        push_i(16'h0002, cyc);
        step();
        instrmem_rd = 1'b0;

        // Preload and data write on the same edge to one word: preload wins.
        data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3030; Data_din = 16'hAAAA;
        load_en = 1'b1; load_addr = 16'h3030; load_data = 16'h5555;
        push_d(16'h0000, cyc);
        step();
        load_en = 1'b0; data_req = 1'b0;
        instrmem_rd = 1'b1; pc = 16'h3030;
        push_i(16'h5555, cyc);
        step();
        instrmem_rd = 1'b0;

        for (int k = 0; k < 20 && (iq.size() != 0 || dq.size() != 0); k++)
            step();
        step();
        @(negedge clock);
        check("instr_queue_drained", iq.size(), 32'h0);
        check("data_queue_drained", dq.size(), 32'h0);
        check("final_instr_cnt", instr_cnt, n_i);
        check("final_data_cnt", data_cnt, n_d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
